// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : vga_pkg                                                      |
// | Purpose   : Geometry and capture-FSM encoding shared by the camera       |
// |             framebuffer writer and the VGA scan-out controller.          |
// | Contents  : FB_WIDTH, FB_HEIGHT, FB_SIZE, cap_state_t                    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package vga_pkg;

  localparam int FB_WIDTH  = 176;
  localparam int FB_HEIGHT = 144;
  localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;  // 25344, base of bank 1

  typedef enum logic [1:0] {
    SYNC   = 2'd0,  // wait for blanking so a partial frame is never captured
    VBLANK = 2'd1,  // between frames
    ACTIVE = 2'd2,  // capturing into the back bank
    SKIP   = 2'd3   // frame dropped, previous frame still awaiting swap
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : edge_detect                                                  |
// | Purpose   : Rise/fall pulses of a synchronous level, derived from a      |
// |             registered copy of that level.                               |
// | Ports     : vga_clk_25 - clock                                           |
// |             reset      - synchronous active-high reset                   |
// |             i_sig      - level to watch                                  |
// |             o_rise     - high for the cycle in which i_sig goes 0->1     |
// |             o_fall     - high for the cycle in which i_sig goes 1->0     |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module edge_detect (
  input  logic vga_clk_25,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge vga_clk_25) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule
`default_nettype wire

// File: rtl/fb_capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fb_capture_writer                                            |
// | Purpose   : Captures a RAW camera stream into a ping-pong framebuffer,   |
// |             validates frame geometry and hands finished frames to the    |
// |             VGA side only at a VGA frame boundary.                       |
// | Ports     : vga_clk_25, reset          - clock, sync active-high reset   |
// |             cam_vsync/href/valid/data  - camera pixel stream             |
// |             vga_frame_start            - scan-out restart pulse          |
// |             wr_en/wr_addr/wr_data      - registered framebuffer write    |
// |             disp_bank, rd_base         - bank shown by scan-out          |
// |             frame_done, frame_err      - frame accepted / rejected pulse |
// |             drop_count                 - saturating skipped-frame count  |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module fb_capture_writer #(
  parameter int FB_WIDTH   = vga_pkg::FB_WIDTH,
  parameter int FB_HEIGHT  = vga_pkg::FB_HEIGHT,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  vga_clk_25,
  input  logic                  reset,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_valid,
  input  logic [DATA_WIDTH-1:0] cam_data,
  input  logic                  vga_frame_start,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  disp_bank,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [7:0]            drop_count
);

  import vga_pkg::*;

  // x counts 0..FB_WIDTH; y counts 0..FB_HEIGHT+1 and parks at the top value
  // so a runaway line count can never wrap back onto FB_HEIGHT.
  localparam int c_xw = $clog2(FB_WIDTH + 1);
  localparam int c_yw = $clog2(FB_HEIGHT + 2);

  localparam logic [c_xw-1:0]       c_x_full     = c_xw'(FB_WIDTH);
  localparam logic [c_xw-1:0]       c_x_one      = c_xw'(1);
  localparam logic [c_yw-1:0]       c_y_full     = c_yw'(FB_HEIGHT);
  localparam logic [c_yw-1:0]       c_y_sat      = c_yw'(FB_HEIGHT + 1);
  localparam logic [c_yw-1:0]       c_y_one      = c_yw'(1);
  localparam logic [ADDR_WIDTH-1:0] c_line_step  = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_bank1_base = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT);

  cap_state_t            r_state;
  logic [c_xw-1:0]       r_x;
  logic [c_yw-1:0]       r_y;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic                  r_err_flag;
  logic                  r_swap_pending;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_disp_bank;
  logic [ADDR_WIDTH-1:0] r_rd_base;
  logic                  r_frame_done;
  logic                  r_frame_err;
  logic [7:0]            r_drop_count;

  logic                  w_vs_rise;
  logic                  w_vs_fall;
  logic                  w_href_rise;
  logic                  w_href_fall;
  logic [c_xw-1:0]       w_x_cur;
  logic                  w_pixel;
  logic                  w_pix_ok;
  logic                  w_pix_bad;
  logic                  w_line_bad;
  logic [c_yw-1:0]       w_y_next;
  logic                  w_frame_ok;
  logic [ADDR_WIDTH-1:0] w_bank_base;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_swap;

  edge_detect u_vsync_edge (
    .vga_clk_25 (vga_clk_25),
    .reset      (reset),
    .i_sig      (cam_vsync),
    .o_rise     (w_vs_rise),
    .o_fall     (w_vs_fall)
  );

  edge_detect u_href_edge (
    .vga_clk_25 (vga_clk_25),
    .reset      (reset),
    .i_sig      (cam_href),
    .o_rise     (w_href_rise),
    .o_fall     (w_href_fall)
  );

  always_comb begin
    // Every line restarts at column 0, even if the counter were left dirty.
    w_x_cur     = w_href_rise ? '0 : r_x;
    w_pixel     = cam_href & cam_valid;
    w_pix_ok    = w_pixel & (w_x_cur < c_x_full) & (r_y < c_y_full);
    w_pix_bad   = w_pixel & ~w_pix_ok;
    w_line_bad  = w_href_fall & (r_x != c_x_full);
    // Line bookkeeping is folded in first so a line end coinciding with the
    // frame end is counted before the geometry check.
    w_y_next    = (w_href_fall && (r_y != c_y_sat)) ? r_y + c_y_one : r_y;
    w_frame_ok  = (w_y_next == c_y_full) & ~r_err_flag & ~w_pix_bad & ~w_line_bad;
    // Back bank is the one not on display.
    w_bank_base = r_disp_bank ? '0 : c_bank1_base;
    w_addr      = w_bank_base + r_line_base + ADDR_WIDTH'(w_x_cur);
    w_swap      = vga_frame_start & r_swap_pending;
  end

  always_ff @(posedge vga_clk_25) begin
    if (reset) begin
      r_state        <= SYNC;
      r_x            <= '0;
      r_y            <= '0;
      r_line_base    <= '0;
      r_err_flag     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_disp_bank    <= 1'b0;
      r_rd_base      <= '0;
      r_frame_done   <= 1'b0;
      r_frame_err    <= 1'b0;
      r_drop_count   <= 8'd0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      if (w_swap) begin
        r_disp_bank    <= ~r_disp_bank;
        r_rd_base      <= r_disp_bank ? '0 : c_bank1_base;
        r_swap_pending <= 1'b0;
      end

      case (r_state)
        SYNC: begin
          if (cam_vsync) begin
            r_state <= VBLANK;
          end
        end

        VBLANK: begin
          if (w_vs_fall) begin
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_err_flag  <= 1'b0;
            // A swap landing on this very cycle frees the back bank, so the
            // new frame is captured rather than dropped.
            if (r_swap_pending && !vga_frame_start) begin
              r_state <= SKIP;
              if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
              end
            end else begin
              r_state <= ACTIVE;
            end
          end
        end

        ACTIVE: begin
          if (w_pix_ok) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_data <= cam_data;
          end
          if (w_pixel) begin
            r_x <= (w_x_cur == c_x_full) ? w_x_cur : w_x_cur + c_x_one;
          end
          if (w_pix_bad) begin
            r_err_flag <= 1'b1;
          end
          if (w_href_fall) begin
            if (w_line_bad) begin
              r_err_flag <= 1'b1;
            end
            r_x         <= '0;
            r_y         <= w_y_next;
            r_line_base <= r_line_base + c_line_step;
          end
          if (w_vs_rise) begin
            if (w_frame_ok) begin
              r_frame_done   <= 1'b1;
              r_swap_pending <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_err_flag  <= 1'b0;
            r_state     <= VBLANK;
          end
        end

        SKIP: begin
          if (w_vs_rise) begin
            r_state <= VBLANK;
          end
        end

        default: r_state <= SYNC;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign disp_bank  = r_disp_bank;
  assign rd_base    = r_rd_base;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire
